// File: rtl/sgd_x_rd_pkg.sv
// Shared types and helpers for the x BRAM reader (sgd_x_rd).
// Optional credit-desync check is enabled with SGD_X_RD_CREDIT_CHECK_EN.
package sgd_x_rd_pkg;

  localparam int CREDIT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_EPOCH,
    ST_WAIT_CREDIT,
    ST_READING,
    ST_DRAIN_WAIT,
    ST_DONE
  } state_t;

  // Chunks needed to cover dim features; a partial chunk counts as a whole one.
  function automatic logic [31:0] chunk_count(input logic [31:0] dim, input int shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (dim >> shift) + {31'd0, |(dim & mask)};
  endfunction

endpackage

// File: rtl/sgd_x_rd_fifo.sv
// Synchronous FIFO holding returned x chunks (with their last tag) ahead of the consumer.
// Read data is combinational from the head entry and stays put until popped.
module sgd_x_rd_fifo #(
  parameter int W     = 513,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (count != ($clog2(DEPTH)+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sgd_x_rd.sv
// Credit-gated reader of the local x BRAM feeding the ax pipeline.
// Define SGD_X_RD_CREDIT_CHECK_EN to flag writer/reader credit desync on x_rd_error.
module sgd_x_rd
  import sgd_x_rd_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 10,
  parameter int CHUNK_SHIFT = 6,
  parameter int NUM_BANKS   = 8,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                started,
  input  logic [31:0]         dimension,
  input  logic [31:0]         number_of_epochs,
  input  logic [31:0]         number_of_samples,
  input  logic [CREDIT_W-1:0] x_wr_credit_counter,
  output logic                x_rd_en,
  output logic [ADDR_W-1:0]   x_rd_addr,
  input  logic [DATA_W-1:0]   x_rd_data,
  output logic                x_out_valid,
  input  logic                x_out_ready,
  output logic [DATA_W-1:0]   x_out_data,
  output logic                x_out_last,
  output logic                x_rd_done,
  output logic                x_rd_error,
  output state_t              fsm_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  state_t              state;
  state_t              state_nx;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] consumed;
  logic [CREDIT_W-1:0] avail;
  logic [31:0]         nchunk;
  logic [31:0]         ngroup;
  logic [31:0]         nepoch;
  logic [31:0]         nchunk_in;
  logic [31:0]         ngroup_in;
  logic [31:0]         epoch_idx;
  logic [31:0]         group_idx;
  logic [ADDR_W-1:0]   chunk_idx;
  logic [RD_LAT-1:0]   vld_sr;
  logic [RD_LAT-1:0]   last_sr;
  logic [OCC_W-1:0]    inflight_cnt;
  logic [OCC_W-1:0]    occ;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic [DATA_W:0]     fifo_dout;
  logic                issue;
  logic                last_chunk;
  logic                cfg_zero;
  logic                drained;
  logic                done_r;
  logic                error_r;

  assign avail      = credit_r - consumed;
  assign nchunk_in  = chunk_count(dimension, CHUNK_SHIFT);
  assign ngroup_in  = number_of_samples / 32'(NUM_BANKS)
                    + {31'd0, (number_of_samples % 32'(NUM_BANKS)) != 32'd0};
  assign cfg_zero   = (nchunk_in == 32'd0) || (ngroup_in == 32'd0);
  assign last_chunk = (32'(chunk_idx) == nchunk - 32'd1);

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + OCC_W'(vld_sr[i]);
  end

  // Pops in the same cycle are ignored, so the issue decision is conservative.
  assign occ     = OCC_W'(fifo_count) + inflight_cnt;
  assign drained = fifo_empty && (inflight_cnt == '0);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE:        if (started) state_nx = ST_START;
      ST_START:       state_nx = cfg_zero ? ST_DONE : ST_EPOCH;
      ST_EPOCH:       state_nx = (epoch_idx == nepoch) ? ST_DRAIN_WAIT : ST_WAIT_CREDIT;
      ST_WAIT_CREDIT: if (avail != '0) state_nx = ST_READING;
      ST_READING: begin
        if (occ < OCC_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (last_chunk)
            state_nx = (group_idx + 32'd1 == ngroup) ? ST_EPOCH : ST_WAIT_CREDIT;
        end
      end
      ST_DRAIN_WAIT:  if (drained) state_nx = ST_DONE;
      ST_DONE:        state_nx = ST_DONE;
      default:        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      credit_r  <= '0;
      consumed  <= '0;
      nchunk    <= '0;
      ngroup    <= '0;
      nepoch    <= '0;
      epoch_idx <= '0;
      group_idx <= '0;
      chunk_idx <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      credit_r <= x_wr_credit_counter;
      vld_sr   <= (vld_sr << 1) | RD_LAT'(issue);
      last_sr  <= (last_sr << 1) | RD_LAT'(issue & last_chunk);
      case (state)
        ST_START: begin
          nchunk    <= nchunk_in;
          ngroup    <= ngroup_in;
          nepoch    <= number_of_epochs;
          epoch_idx <= '0;
          if (cfg_zero) error_r <= 1'b1;
        end
        ST_EPOCH: begin
          if (epoch_idx != nepoch) begin
            epoch_idx <= epoch_idx + 32'd1;
            group_idx <= '0;
          end
        end
        ST_WAIT_CREDIT: begin
          // The credit is spent on entry to READING, not when the pass completes.
          if (avail != '0) begin
            consumed  <= consumed + 1'b1;
            chunk_idx <= '0;
          end
        end
        ST_READING: begin
          if (issue) begin
            if (last_chunk) group_idx <= group_idx + 32'd1;
            else            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        ST_DONE: if (drained) done_r <= 1'b1;
        default: ;
      endcase
`ifdef SGD_X_RD_CREDIT_CHECK_EN
      if (avail > 8'd128) error_r <= 1'b1;
`endif
    end
  end

  // Returned data is always accepted; the issue rule keeps the FIFO from overflowing.
  sgd_x_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_sr[RD_LAT-1]),
    .push_data ({last_sr[RD_LAT-1], x_rd_data}),
    .pop       (x_out_valid & x_out_ready),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Output handshake: a chunk transfers on a cycle with x_out_valid & x_out_ready;
  // while valid is high and ready low, data and last do not change.
  assign x_rd_en     = issue;
  assign x_rd_addr   = issue ? chunk_idx : '0;
  assign x_out_valid = ~fifo_empty;
  assign x_out_data  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign x_out_last  = ~fifo_empty & fifo_dout[DATA_W];
  assign x_rd_done   = done_r;
  assign x_rd_error  = error_r;
  assign fsm_state   = state;

endmodule

// File: tb/tb_sgd_x_rd.sv
// Self-checking bench for sgd_x_rd: BRAM model, scoreboard on the output stream, scenario tasks.
module tb_sgd_x_rd;
  import sgd_x_rd_pkg::*;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              started;
  logic [31:0]       dimension;
  logic [31:0]       number_of_epochs;
  logic [31:0]       number_of_samples;
  logic [7:0]        x_wr_credit_counter;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [DATA_W-1:0] x_rd_data;
  logic              x_out_valid;
  logic              x_out_ready;
  logic [DATA_W-1:0] x_out_data;
  logic              x_out_last;
  logic              x_rd_done;
  logic              x_rd_error;
  state_t            fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sgd_x_rd dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .started             (started),
    .dimension           (dimension),
    .number_of_epochs    (number_of_epochs),
    .number_of_samples   (number_of_samples),
    .x_wr_credit_counter (x_wr_credit_counter),
    .x_rd_en             (x_rd_en),
    .x_rd_addr           (x_rd_addr),
    .x_rd_data           (x_rd_data),
    .x_out_valid         (x_out_valid),
    .x_out_ready         (x_out_ready),
    .x_out_data          (x_out_data),
    .x_out_last          (x_out_last),
    .x_rd_done           (x_rd_done),
    .x_rd_error          (x_rd_error),
    .fsm_state           (fsm_state)
  );

  // BRAM model, two-cycle read latency
  logic [DATA_W-1:0] xmem [1024];
  logic [DATA_W-1:0] rd_p0;
  logic [DATA_W-1:0] rd_p1;
  always @(posedge clk) begin
    if (x_rd_en) rd_p0 <= xmem[x_rd_addr];
    rd_p1 <= rd_p0;
  end
  assign x_rd_data = rd_p1;

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int out_cnt  = 0;
  bit stall_prev = 1'b0;
  logic [DATA_W:0] stall_word;
  logic [DATA_W:0] exp_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (x_rd_en) en_cnt++;
      if (stall_prev) begin
        n_checks++;
        if (x_out_valid !== 1'b1 || {x_out_last, x_out_data} !== stall_word)
          $display("FAIL hold_stable: got valid=%0b word=%0h expected valid=1 word=%0h",
                   x_out_valid, {x_out_last, x_out_data}, stall_word);
        else n_pass++;
      end
      if (x_out_valid === 1'b1 && x_out_ready === 1'b1) begin
        out_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got word=%0h expected no output", {x_out_last, x_out_data});
        end else begin
          exp_word = exp_q.pop_front();
          if ({x_out_last, x_out_data} !== exp_word)
            $display("FAIL sb_chunk: got %0h expected %0h", {x_out_last, x_out_data}, exp_word);
          else n_pass++;
        end
      end
      stall_prev = (x_out_valid === 1'b1) && (x_out_ready === 1'b0);
      stall_word = {x_out_last, x_out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    started             = 1'b0;
    dimension           = '0;
    number_of_epochs    = '0;
    number_of_samples   = '0;
    x_wr_credit_counter = '0;
    x_out_ready         = 1'b1;
    ticks(3);
    exp_q.delete();
    en_cnt  = 0;
    out_cnt = 0;
    rst_n   = 1'b1;
  endtask

  task automatic start_job(input int dim, input int samples, input int epochs);
    dimension         = dim;
    number_of_samples = samples;
    number_of_epochs  = epochs;
    started           = 1'b1;
  endtask

  task automatic push_pass(input int nchunk);
    for (int c = 0; c < nchunk; c++) exp_q.push_back({c == nchunk - 1, xmem[c]});
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (x_rd_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_en(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (en_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({x_rd_en, x_rd_addr, x_out_valid, x_out_last, x_rd_done, x_rd_error} !== '0)
      $display("FAIL reset_ctrl: got en=%0b addr=%0h valid=%0b last=%0b done=%0b err=%0b expected all 0",
               x_rd_en, x_rd_addr, x_out_valid, x_out_last, x_rd_done, x_rd_error);
    else n_pass++;
    n_checks++;
    if (x_out_data !== '0) $display("FAIL reset_data: got %0h expected 0", x_out_data);
    else n_pass++;
    n_checks++;
    if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_credit_gating();
    bit ok;
    do_reset();
    push_pass(2);
    push_pass(2);
    start_job(128, 16, 1);
    ticks(20);
    n_checks++;
    if (en_cnt !== 0) $display("FAIL gate_no_credit: got %0d reads expected 0", en_cnt);
    else n_pass++;
    x_wr_credit_counter = 8'd1;
    ticks(15);
    n_checks++;
    if (en_cnt !== 2 || out_cnt !== 2)
      $display("FAIL gate_pass1: got reads=%0d outs=%0d expected 2/2", en_cnt, out_cnt);
    else n_pass++;
    ticks(20);
    n_checks++;
    if (en_cnt !== 2 || x_rd_done !== 1'b0)
      $display("FAIL gate_stall: got reads=%0d done=%0b expected 2/0", en_cnt, x_rd_done);
    else n_pass++;
    x_wr_credit_counter = 8'd2;
    wait_done(60, ok);
    n_checks++;
    if (!ok || en_cnt !== 4 || exp_q.size() !== 0 || x_rd_error !== 1'b0)
      $display("FAIL gate_done: got done=%0b reads=%0d left=%0d err=%0b expected 1/4/0/0",
               ok, en_cnt, exp_q.size(), x_rd_error);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    x_out_ready = 1'b0;
    push_pass(16);
    x_wr_credit_counter = 8'd1;
    start_job(1024, 8, 1);
    ticks(30);
    n_checks++;
    if (en_cnt !== 8 || out_cnt !== 0 || x_out_valid !== 1'b1)
      $display("FAIL bp_outstanding: got reads=%0d outs=%0d valid=%0b expected 8/0/1",
               en_cnt, out_cnt, x_out_valid);
    else n_pass++;
    x_out_ready = 1'b1;
    wait_done(100, ok);
    n_checks++;
    if (!ok || en_cnt !== 16 || out_cnt !== 16 || exp_q.size() !== 0)
      $display("FAIL bp_release: got done=%0b reads=%0d outs=%0d left=%0d expected 1/16/16/0",
               ok, en_cnt, out_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_credit_wrap();
    bit ok;
    do_reset();
    for (int p = 0; p < 257; p++) push_pass(1);
    x_wr_credit_counter = 8'd254;
    start_job(64, 257 * 8, 1);
    wait_en(254, 1000, ok);
    ticks(10);
    n_checks++;
    if (!ok || en_cnt !== 254) $display("FAIL wrap_254: got %0d passes expected 254", en_cnt);
    else n_pass++;
    x_wr_credit_counter = 8'd255;
    ticks(10);
    n_checks++;
    if (en_cnt !== 255) $display("FAIL wrap_255: got %0d passes expected 255", en_cnt);
    else n_pass++;
    x_wr_credit_counter = 8'd0;
    ticks(10);
    n_checks++;
    if (en_cnt !== 256) $display("FAIL wrap_0: got %0d passes expected 256", en_cnt);
    else n_pass++;
    x_wr_credit_counter = 8'd1;
    wait_done(50, ok);
    n_checks++;
    if (!ok || en_cnt !== 257 || out_cnt !== 257 || exp_q.size() !== 0)
      $display("FAIL wrap_done: got done=%0b reads=%0d outs=%0d left=%0d expected 1/257/257/0",
               ok, en_cnt, out_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_dim();
    bit ok;
    do_reset();
    x_wr_credit_counter = 8'd5;
    start_job(0, 16, 1);
    wait_done(30, ok);
    n_checks++;
    if (!ok || x_rd_error !== 1'b1 || en_cnt !== 0)
      $display("FAIL zero_dim: got done=%0b err=%0b reads=%0d expected 1/1/0", ok, x_rd_error, en_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    x_out_ready = 1'b0;
    x_wr_credit_counter = 8'd1;
    start_job(1024, 8, 1);
    ticks(6);
    n_checks++;
    if (en_cnt == 0) $display("FAIL midrst_reading: got %0d reads expected >0", en_cnt);
    else n_pass++;
    rst_n   = 1'b0;
    started = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({x_rd_en, x_rd_addr, x_out_valid, x_out_last, x_rd_done, x_rd_error} !== '0 || x_out_data !== '0)
      $display("FAIL midrst_outputs: got en=%0b addr=%0h valid=%0b last=%0b done=%0b err=%0b expected all 0",
               x_rd_en, x_rd_addr, x_out_valid, x_out_last, x_rd_done, x_rd_error);
    else n_pass++;
    ticks(4);
    exp_q.delete();
    en_cnt  = 0;
    out_cnt = 0;
    rst_n   = 1'b1;
    ticks(2);
    n_checks++;
    if (x_out_valid !== 1'b0) $display("FAIL midrst_fifo_empty: got valid=%0b expected 0", x_out_valid);
    else n_pass++;
    push_pass(16);
    x_out_ready = 1'b1;
    start_job(1024, 8, 1);
    wait_done(100, ok);
    n_checks++;
    if (!ok || out_cnt !== 16 || exp_q.size() !== 0)
      $display("FAIL midrst_restart: got done=%0b outs=%0d left=%0d expected 1/16/0", ok, out_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_credit_jump();
    bit ok;
    do_reset();
    for (int p = 0; p < 200; p++) push_pass(1);
    x_wr_credit_counter = 8'd200;
    start_job(64, 1600, 1);
    wait_done(1000, ok);
    n_checks++;
`ifdef SGD_X_RD_CREDIT_CHECK_EN
    if (x_rd_error !== 1'b1) $display("FAIL jump_error: got %0b expected 1", x_rd_error);
    else n_pass++;
`else
    if (x_rd_error !== 1'b0) $display("FAIL jump_error: got %0b expected 0", x_rd_error);
    else n_pass++;
`endif
    n_checks++;
    if (!ok || out_cnt !== 200 || exp_q.size() !== 0)
      $display("FAIL jump_passes: got done=%0b outs=%0d left=%0d expected 1/200/0", ok, out_cnt, exp_q.size());
    else n_pass++;
  endtask

  // ---------------- main ----------------
  initial begin
    for (int a = 0; a < 1024; a++)
      for (int k = 0; k < DATA_W / 32; k++) xmem[a][k*32 +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
    rd_p0 = '0;
    rd_p1 = '0;
    test_reset();
    test_credit_gating();
    test_backpressure();
    test_credit_wrap();
    test_zero_dim();
    test_mid_reset();
    test_credit_jump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
